// File: rtl/c432_key_pkg.sv
// Shared constants, state encoding and parity helper for the c432 key loader.
// The key feeds the locked c432 netlist: four MUX-key bits p1..p4, then thirty XOR-key bits.
package c432_key_pkg;

  localparam int KEY_W     = 34;
  localparam int P_W       = 4;
  localparam int X_W       = 30;
  localparam int FRAME_LEN = KEY_W + 1;
  localparam int P_LSB     = 0;
  localparam int X_LSB     = P_LSB + P_W;
  localparam int CNT_W     = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic parity_step(input logic acc, input logic data_bit);
    return acc ^ data_bit;
  endfunction

endpackage

// File: rtl/c432_key_shift.sv
// Shadow register, bit counter and running even-parity accumulator for one key frame.
// clr_i has priority over accept_i so a restart always discards the bit of that cycle.
module c432_key_shift
  import c432_key_pkg::*;
#(
  parameter int KEY_W   = c432_key_pkg::KEY_W,
  parameter int SHIFT_W = c432_key_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             accept_i,
  input  logic             bit_i,
  output logic [KEY_W-1:0] shadow_o,
  output logic             parity_o,
  output logic             last_o
);

  localparam logic [SHIFT_W-1:0] LAST_IDX = SHIFT_W'(KEY_W);

  logic [KEY_W-1:0]   shadow_q, shadow_d;
  logic [SHIFT_W-1:0] cnt_q, cnt_d;
  logic               parity_q, parity_d;

  // Next-state: clear, accept one serial bit, or hold.
  always_comb begin
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    parity_d = parity_q;
    if (clr_i) begin
      shadow_d = '0;
      cnt_d    = '0;
      parity_d = 1'b0;
    end else if (accept_i) begin
      parity_d = parity_step(parity_q, bit_i);
      // The parity bit (index KEY_W) only feeds the accumulator; the counter saturates there.
      if (cnt_q != LAST_IDX) begin
        shadow_d[cnt_q] = bit_i;
        cnt_d           = cnt_q + SHIFT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      parity_d = parity_q;
    end
  end

  // Frame state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
      cnt_q    <= '0;
      parity_q <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      parity_q <= parity_d;
    end
  end

  assign shadow_o = shadow_q;
  assign parity_o = parity_q;
  assign last_o   = (cnt_q == LAST_IDX);

endmodule

// File: rtl/c432_key_loader.sv
// Serial key loader for the locked c432 netlist: receives a parity-protected frame,
// commits it once on good parity and then holds it until reset (one-time programmable).
module c432_key_loader
  import c432_key_pkg::*;
#(
  parameter int KEY_W = c432_key_pkg::KEY_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_start,
  input  logic             key_sdi,
  input  logic             key_sdi_valid,
  output logic [KEY_W-1:0] key_out,
  output logic             key_ready,
  output logic             key_err,
  output logic             busy
);

  localparam int SHIFT_W = $clog2(KEY_W + 1);

  state_e           state_q, state_d;
  logic [KEY_W-1:0] key_out_q, key_out_d;
  logic             key_ready_q, key_ready_d;
  logic             key_err_q, key_err_d;
  logic             shift_clr_s, shift_accept_s;
  logic [KEY_W-1:0] shadow_s;
  logic             parity_s;
  logic             last_s;

  c432_key_shift #(
    .KEY_W   (KEY_W),
    .SHIFT_W (SHIFT_W)
  ) u_shift (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (shift_clr_s),
    .accept_i (shift_accept_s),
    .bit_i    (key_sdi),
    .shadow_o (shadow_s),
    .parity_o (parity_s),
    .last_o   (last_s)
  );

  // Frame sequencing and commit decision.
  always_comb begin
    state_d        = state_q;
    key_out_d      = key_out_q;
    key_ready_d    = key_ready_q;
    key_err_d      = key_err_q;
    shift_clr_s    = 1'b0;
    shift_accept_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (key_start) begin
          state_d     = ST_SHIFT;
          shift_clr_s = 1'b1;
          key_err_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (key_start) begin
          shift_clr_s = 1'b1;
        end else if (key_sdi_valid) begin
          shift_accept_s = 1'b1;
          if (last_s) begin
            state_d = ST_CHECK;
          end else begin
            state_d = ST_SHIFT;
          end
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_CHECK: begin
        if (parity_s == 1'b0) begin
          key_out_d   = shadow_s;
          key_ready_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          key_err_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and committed-key registers; only reset can leave DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      key_out_q   <= '0;
      key_ready_q <= 1'b0;
      key_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_out_q   <= key_out_d;
      key_ready_q <= key_ready_d;
      key_err_q   <= key_err_d;
    end
  end

  assign key_out   = key_out_q;
  assign key_ready = key_ready_q;
  assign key_err   = key_err_q;
  assign busy      = (state_q == ST_SHIFT) || (state_q == ST_CHECK);

endmodule

// File: tb/tb_c432_key_loader.sv
// Scoreboard bench: stimulus pushes expected results from a frame-level model,
// a monitor pops and compares whenever key_ready or key_err rises.
module tb_c432_key_loader;

  localparam int KW = 34;

  typedef struct packed {
    logic [KW-1:0] key;
    logic          ready;
    logic          err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          key_start = 1'b0;
  logic          key_sdi = 1'b0;
  logic          key_sdi_valid = 1'b0;
  logic [KW-1:0] key_out;
  logic          key_ready;
  logic          key_err;
  logic          busy;

  exp_t          exp_q[$];
  int            checks = 0;
  int            errors = 0;
  logic [KW-1:0] model_key = '0;
  bit            model_done = 1'b0;

  always #5 clk = ~clk;

  c432_key_loader #(.KEY_W(KW)) dut (
    .clk           (clk),
    .rst           (rst),
    .key_start     (key_start),
    .key_sdi       (key_sdi),
    .key_sdi_valid (key_sdi_valid),
    .key_out       (key_out),
    .key_ready     (key_ready),
    .key_err       (key_err),
    .busy          (busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_key_out", key_out, 0);
    check("rst_key_ready", key_ready, 0);
    check("rst_key_err", key_err, 0);
    check("rst_busy", busy, 0);
    tick();
    rst = 1'b0;
    model_key  = '0;
    model_done = 1'b0;
    exp_q.delete();
  endtask

  task automatic send_bit(input logic b, input int maxgap);
    int g;
    g = (maxgap > 0) ? $urandom_range(maxgap, 1) : 0;
    repeat (g) begin
      key_sdi_valid = 1'b0;
      key_sdi       = 1'($urandom);
      tick();
    end
    key_sdi_valid = 1'b1;
    key_sdi       = b;
    tick();
    key_sdi_valid = 1'b0;
  endtask

  // Start pulse with a valid '1' bit in the same cycle: that bit must be dropped.
  task automatic start_pulse();
    key_start     = 1'b1;
    key_sdi_valid = 1'b1;
    key_sdi       = 1'b1;
    tick();
    key_start     = 1'b0;
    key_sdi_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  task automatic send_frame(input logic [KW-1:0] key, input logic par, input int maxgap);
    bit   ok;
    bit   live;
    exp_t e;
    ok   = (((^key) ^ par) == 1'b0);
    live = !model_done;
    start_pulse();
    if (live) check("busy_after_start", busy, 1);
    for (int i = 0; i < KW; i++) send_bit(key[i], maxgap);
    if (live) begin
      if (ok) begin
        model_key  = key;
        model_done = 1'b1;
        e.key = key; e.ready = 1'b1; e.err = 1'b0;
      end else begin
        e.key = model_key; e.ready = 1'b0; e.err = 1'b1;
      end
      exp_q.push_back(e);
    end
    send_bit(par, maxgap);
    if (live) begin
      check("no_result_after_parity_edge", {key_ready, key_err}, 0);
      check("busy_in_check", busy, 1);
      tick();
      check("result_at_second_edge", key_ready | key_err, 1);
      check("busy_after_result", busy, 0);
    end
    drain();
  endtask

  initial begin : monitor
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b0;
      end else begin
        if ((key_ready | key_err) && !prev) begin
          if (exp_q.size() == 0) begin
            check("unexpected_result", {key_ready, key_err}, 0);
          end else begin
            e = exp_q.pop_front();
            check("sb_key_out", key_out, e.key);
            check("sb_key_ready", key_ready, e.ready);
            check("sb_key_err", key_err, e.err);
          end
        end
        prev = key_ready | key_err;
      end
    end
  end

  initial begin : timeout
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin : stimulus
    logic [KW-1:0] k;
    logic [KW-1:0] ones;
    ones = '1;

    do_reset();

    // All-ones key, even parity 0
    send_frame(ones, 1'b0, 0);
    check("ones_key_out", key_out, 34'h3_FFFF_FFFF);
    check("ones_key_ready", key_ready, 1);

    // DONE is terminal: a new bad frame changes nothing
    send_frame(34'h0_1234_5678, 1'b0, 0);
    repeat (3) tick();
    check("done_hold_key_out", key_out, 34'h3_FFFF_FFFF);
    check("done_hold_ready", key_ready, 1);
    check("done_hold_err", key_err, 0);
    check("done_hold_busy", busy, 0);

    // Odd total parity
    do_reset();
    send_frame(34'h0_0000_0005, 1'b1, 0);
    check("odd_key_err", key_err, 1);
    check("odd_key_ready", key_ready, 0);
    check("odd_key_out", key_out, 0);
    check("odd_busy", busy, 0);
    // Retry after an error clears key_err and commits
    send_frame(34'h0_0000_0005, 1'b0, 0);
    check("retry_key_out", key_out, 34'h0_0000_0005);
    check("retry_key_err", key_err, 0);

    // Restart mid-frame
    do_reset();
    start_pulse();
    for (int i = 0; i < 10; i++) send_bit(1'($urandom), 0);
    send_frame(34'h2_AAAA_AAAA, 1'b1, 0);
    check("restart_key_out", key_out, 34'h2_AAAA_AAAA);
    check("restart_key_ready", key_ready, 1);

    // Reset after 20 bits, then a clean frame
    do_reset();
    start_pulse();
    for (int i = 0; i < 20; i++) send_bit(1'b1, 0);
    check("mid_frame_busy", busy, 1);
    do_reset();
    k = 34'h1_2345_6789;
    send_frame(k, ^k, 0);
    check("post_rst_key_out", key_out, k);

    // Random keys, gap-free and with 1-5 cycle gaps, some preceded by a bad frame
    for (int n = 0; n < 6; n++) begin
      k = KW'({$urandom, $urandom});
      do_reset();
      send_frame(k, ^k, 0);
      check("rand_nogap_key_out", key_out, k);
      do_reset();
      if ($urandom_range(1, 0) == 1) send_frame(k, ~(^k), 5);
      send_frame(k, ^k, 5);
      check("rand_gap_key_out", key_out, k);
      check("rand_gap_key_ready", key_ready, 1);
    end

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
